// File: rtl/julia_pkg.sv
// Shared fixed-point types, constants and the mapper state encoding
// used by the Julia front end.
package julia_pkg;

    localparam int WIDTH      = 22;
    localparam int FRACTIONAL = 11;

    typedef logic signed [WIDTH-1:0] fixp_t;

    localparam fixp_t FIXP_ONE = fixp_t'(1 << FRACTIONAL);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } mapper_state_t;

endpackage

// File: rtl/pixel_plane_mapper_if.sv
// Point stream from the pixel plane mapper to the iteration workers:
// valid/ready handshake carrying z0, its pixel coordinates and a frame-last flag.
interface pixel_plane_mapper_if #(
    parameter int WIDTH = 22,
    parameter int XW    = 10,
    parameter int YW    = 10
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] z_real_out;
    logic signed [WIDTH-1:0] z_imag_out;
    logic [XW-1:0]           x_out;
    logic [YW-1:0]           y_out;
    logic                    last_out;

    modport master (
        output out_valid, z_real_out, z_imag_out, x_out, y_out, last_out,
        input  out_ready
    );

    modport slave (
        input  out_valid, z_real_out, z_imag_out, x_out, y_out, last_out,
        output out_ready
    );
endinterface

// File: rtl/raster_counter.sv
// Column/row counters for one frame walk: column wraps at H_RES-1, row
// advances by a runtime stride; flags the last pixel of the visited rows.
module raster_counter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int XW    = 10,
    parameter int YW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    input  logic [YW-1:0] row_first,
    input  logic [YW-1:0] row_stride,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          row_end,
    output logic          frame_last
);

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW:0]   V_LIM  = (YW + 1)'(V_RES);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [YW:0]   y_next_wide;

    // One extra bit so a stride stepping past the frame never aliases back in.
    assign y_next_wide = {1'b0, y_q} + {1'b0, row_stride};
    assign row_end     = (x_q == X_LAST);
    assign frame_last  = row_end && (y_next_wide >= V_LIM);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load) begin
            x_d = '0;
            y_d = row_first;
        end else if (advance) begin
            if (row_end) begin
                x_d = '0;
                y_d = y_next_wide[YW-1:0];
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/pixel_plane_mapper.sv
// Walks a frame raster and streams one complex start point z0 per pixel,
// built by incremental adds. Optional row interleave: MAPPER_ROW_INTERLEAVE_EN.
module pixel_plane_mapper
    import julia_pkg::*;
#(
    parameter int WIDTH      = julia_pkg::WIDTH,
    parameter int FRACTIONAL = julia_pkg::FRACTIONAL,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int XW         = 10,
    parameter int YW         = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] cfg_origin_re,
    input  logic signed [WIDTH-1:0] cfg_origin_im,
    input  logic signed [WIDTH-1:0] cfg_step,
`ifdef MAPPER_ROW_INTERLEAVE_EN
    input  logic [YW-1:0]           cfg_row_first,
    input  logic [YW-1:0]           cfg_row_stride,
    input  logic signed [WIDTH-1:0] cfg_row_step_im,
`endif
    output logic                    busy,
    output logic                    done,
    pixel_plane_mapper_if.master    m_if
);

    if (FRACTIONAL < 0 || FRACTIONAL >= WIDTH || (1 << XW) < H_RES || (1 << YW) < V_RES)
    begin : g_param_check
        $error("pixel_plane_mapper: inconsistent WIDTH/FRACTIONAL or index widths");
    end

    mapper_state_t state_q, state_d;

    logic signed [WIDTH-1:0] origin_re_q, origin_re_d;
    logic signed [WIDTH-1:0] origin_im_q, origin_im_d;
    logic signed [WIDTH-1:0] step_q, step_d;
    logic signed [WIDTH-1:0] re_acc_q, re_acc_d;
    logic signed [WIDTH-1:0] im_acc_q, im_acc_d;

    logic [YW-1:0]           row_first;
    logic [YW-1:0]           row_stride;
    logic signed [WIDTH-1:0] row_step;

    logic          cnt_load, cnt_advance;
    logic          row_end, frame_last;
    logic [XW-1:0] x_cur;
    logic [YW-1:0] y_cur;
    logic          xfer;

`ifdef MAPPER_ROW_INTERLEAVE_EN
    logic [YW-1:0]           row_first_q, row_first_d;
    logic [YW-1:0]           row_stride_q, row_stride_d;
    logic signed [WIDTH-1:0] row_step_q, row_step_d;

    always_comb begin
        row_first_d  = row_first_q;
        row_stride_d = row_stride_q;
        row_step_d   = row_step_q;
        if (state_q == IDLE && start) begin
            row_first_d  = cfg_row_first;
            row_stride_d = cfg_row_stride;
            row_step_d   = cfg_row_step_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_first_q  <= '0;
            row_stride_q <= '0;
            row_step_q   <= '0;
        end else begin
            row_first_q  <= row_first_d;
            row_stride_q <= row_stride_d;
            row_step_q   <= row_step_d;
        end
    end

    assign row_first  = row_first_q;
    assign row_stride = row_stride_q;
    assign row_step   = row_step_q;
`else
    assign row_first  = '0;
    assign row_stride = YW'(1);
    assign row_step   = step_q;
`endif

    assign xfer = (state_q == RUN) && m_if.out_ready;

    always_comb begin
        state_d     = state_q;
        origin_re_d = origin_re_q;
        origin_im_d = origin_im_q;
        step_d      = step_q;
        re_acc_d    = re_acc_q;
        im_acc_d    = im_acc_q;
        cnt_load    = 1'b0;
        cnt_advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    origin_re_d = cfg_origin_re;
                    origin_im_d = cfg_origin_im;
                    step_d      = cfg_step;
                end
            end
            LOAD: begin
                state_d  = RUN;
                cnt_load = 1'b1;
                re_acc_d = origin_re_q;
                im_acc_d = origin_im_q;
            end
            RUN: begin
                if (xfer) begin
                    // The final point is left on the outputs rather than advanced past the frame.
                    if (frame_last) begin
                        state_d = DONE;
                    end else begin
                        cnt_advance = 1'b1;
                        if (row_end) begin
                            re_acc_d = origin_re_q;
                            im_acc_d = im_acc_q + row_step;
                        end else begin
                            re_acc_d = re_acc_q + step_q;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            origin_re_q <= '0;
            origin_im_q <= '0;
            step_q      <= '0;
            re_acc_q    <= '0;
            im_acc_q    <= '0;
        end else begin
            state_q     <= state_d;
            origin_re_q <= origin_re_d;
            origin_im_q <= origin_im_d;
            step_q      <= step_d;
            re_acc_q    <= re_acc_d;
            im_acc_q    <= im_acc_d;
        end
    end

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .XW    (XW),
        .YW    (YW)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .advance    (cnt_advance),
        .row_first  (row_first),
        .row_stride (row_stride),
        .x          (x_cur),
        .y          (y_cur),
        .row_end    (row_end),
        .frame_last (frame_last)
    );

    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign m_if.out_valid  = (state_q == RUN);
    assign m_if.z_real_out = re_acc_q;
    assign m_if.z_imag_out = im_acc_q;
    assign m_if.x_out      = x_cur;
    assign m_if.y_out      = y_cur;
    assign m_if.last_out   = (state_q == RUN) && frame_last;

endmodule
